idwt_syn: RTL and testbench

IDWT_SYN -- requirements
Module: idwt_syn

---
 rtl/idwt_syn.sv | 141 ++++++++++++++
 tb/tb_idwt_syn.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/idwt_syn.sv
// idwt_syn: two-phase polyphase inverse DWT synthesis stage.
// Each accepted (lo, hi) pair yields an even then an odd reconstructed
// sample. Both phase sums are formed on the accept edge and held until
// they have been drained.

// One output phase: four full-precision taps over current/previous lo and hi.
module idwt_syn_phase #(
  parameter int W_IN  = 20,
  parameter int C_IN  = 5,
  parameter int Y_OUT = W_IN + C_IN + 2
) (
  input  logic signed [W_IN-1:0]  lo_cur,
  input  logic signed [W_IN-1:0]  lo_prv,
  input  logic signed [W_IN-1:0]  hi_cur,
  input  logic signed [W_IN-1:0]  hi_prv,
  input  logic signed [C_IN-1:0]  g_cur,
  input  logic signed [C_IN-1:0]  g_prv,
  input  logic signed [C_IN-1:0]  h_cur,
  input  logic signed [C_IN-1:0]  h_prv,
  output logic signed [Y_OUT-1:0] sum
);
  localparam int P = W_IN + C_IN;

  logic signed [P-1:0] p_lc, p_lp, p_hc, p_hp;

  // Exact products, sign-extended to the output width before the sum
  always_comb begin
    p_lc = P'(lo_cur) * P'(g_cur);
    p_lp = P'(lo_prv) * P'(g_prv);
    p_hc = P'(hi_cur) * P'(h_cur);
    p_hp = P'(hi_prv) * P'(h_prv);
    sum  = Y_OUT'(p_lc) + Y_OUT'(p_lp) + Y_OUT'(p_hc) + Y_OUT'(p_hp);
  end
endmodule

module idwt_syn #(
  parameter int W_IN  = 20,
  parameter int C_IN  = 5,
  parameter int Y_OUT = W_IN + C_IN + 2
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [W_IN-1:0]  lo_in,
  input  logic signed [W_IN-1:0]  hi_in,
  input  logic signed [C_IN-1:0]  g_0,
  input  logic signed [C_IN-1:0]  g_1,
  input  logic signed [C_IN-1:0]  g_2,
  input  logic signed [C_IN-1:0]  g_3,
  input  logic signed [C_IN-1:0]  h_0,
  input  logic signed [C_IN-1:0]  h_1,
  input  logic signed [C_IN-1:0]  h_2,
  input  logic signed [C_IN-1:0]  h_3,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [Y_OUT-1:0] y_out,
  output logic                    y_phase
);
  localparam int NUM_PH = 2;

  typedef enum logic [1:0] {IDLE, EVEN, ODD} state_t;

  state_t state, state_nxt;

  logic signed [W_IN-1:0] lo_d, hi_d;
  logic [NUM_PH-1:0][C_IN-1:0]  gc_cur, gc_prv, hc_cur, hc_prv;
  logic [NUM_PH-1:0][Y_OUT-1:0] sum_c, sum_r;
  logic in_xfer;

  // Phase p uses taps (g_p, g_p+2, h_p, h_p+2)
  assign gc_cur = {g_1, g_0};
  assign gc_prv = {g_3, g_2};
  assign hc_cur = {h_1, h_0};
  assign hc_prv = {h_3, h_2};

  assign in_xfer = in_valid && in_ready;

  for (genvar p = 0; p < NUM_PH; p++) begin : g_ph
    idwt_syn_phase #(.W_IN(W_IN), .C_IN(C_IN), .Y_OUT(Y_OUT)) u_ph (
      .lo_cur (lo_in),
      .lo_prv (lo_d),
      .hi_cur (hi_in),
      .hi_prv (hi_d),
      .g_cur  (gc_cur[p]),
      .g_prv  (gc_prv[p]),
      .h_cur  (hc_cur[p]),
      .h_prv  (hc_prv[p]),
      .sum    (sum_c[p])
    );
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state: a drained odd sample may be replaced by a new pair on the same edge
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (in_xfer)   state_nxt = EVEN;
      EVEN: if (out_ready) state_nxt = ODD;
      ODD:  if (out_ready) state_nxt = in_valid ? EVEN : IDLE;
      default:             state_nxt = IDLE;
    endcase
  end

  // Handshake and output mux; input is only taken when no pending sample would be lost
  always_comb begin
    out_valid = 1'b0;
    in_ready  = 1'b0;
    y_phase   = 1'b0;
    y_out     = sum_r[0];
    unique case (state)
      IDLE: in_ready = rstn;
      EVEN: out_valid = 1'b1;
      ODD: begin
        out_valid = 1'b1;
        y_phase   = 1'b1;
        y_out     = sum_r[1];
        in_ready  = rstn && out_ready;
      end
      default: in_ready = 1'b0;
    endcase
  end

  // History and phase sums capture only on an accepted pair
  always_ff @(posedge clk) begin
    if (!rstn) begin
      lo_d  <= '0;
      hi_d  <= '0;
      sum_r <= '0;
    end else if (in_xfer) begin
      lo_d  <= lo_in;
      hi_d  <= hi_in;
      sum_r <= sum_c;
    end
  end
endmodule

// File: tb/tb_idwt_syn.sv
// tb_idwt_syn: directed and randomized checks of idwt_syn against a
// queue-based model of the synthesis equations.
module tb_idwt_syn;
  localparam int W_IN  = 20;
  localparam int C_IN  = 5;
  localparam int Y_OUT = W_IN + C_IN + 2;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic signed [W_IN-1:0] lo_in = '0, hi_in = '0;
  logic signed [C_IN-1:0] g [4];
  logic signed [C_IN-1:0] h [4];
  logic in_ready, out_valid, y_phase;
  logic signed [Y_OUT-1:0] y_out;

  always #5 clk = ~clk;

  idwt_syn #(.W_IN(W_IN), .C_IN(C_IN), .Y_OUT(Y_OUT)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .lo_in(lo_in), .hi_in(hi_in),
    .g_0(g[0]), .g_1(g[1]), .g_2(g[2]), .g_3(g[3]),
    .h_0(h[0]), .h_1(h[1]), .h_2(h[2]), .h_3(h[3]),
    .out_valid(out_valid), .out_ready(out_ready),
    .y_out(y_out), .y_phase(y_phase)
  );

  typedef struct { longint y; bit ph; } samp_t;
  samp_t  q[$];
  longint lo_p = 0, hi_p = 0;
  int     n_vec = 0, n_err = 0;
  bit     rnd_coef = 0;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_coef(input int g0, g1, g2, g3, h0, h1, h2, h3);
    g[0] = C_IN'(g0); g[1] = C_IN'(g1); g[2] = C_IN'(g2); g[3] = C_IN'(g3);
    h[0] = C_IN'(h0); h[1] = C_IN'(h1); h[2] = C_IN'(h2); h[3] = C_IN'(h3);
  endtask

  // One cycle: drive, check against the model, then advance the model
  // to what the coming rising edge will do.
  task automatic step(input bit r, input bit iv, input longint lo, input longint hi, input bit ordy);
    bit exp_ov, exp_ir;
    samp_t s;
    @(negedge clk);
    rstn = r; in_valid = iv; out_ready = ordy;
    lo_in = W_IN'(lo); hi_in = W_IN'(hi);
    if (rnd_coef)
      for (int i = 0; i < 4; i++) begin g[i] = C_IN'($urandom); h[i] = C_IN'($urandom); end
    #1;
    if (!r) begin
      chk("in_ready_in_reset", in_ready, 0);
      q.delete(); lo_p = 0; hi_p = 0;
    end else begin
      exp_ov = q.size() != 0;
      exp_ir = q.size() == 0 || (q.size() == 1 && ordy);
      chk("out_valid", out_valid, exp_ov);
      chk("in_ready", in_ready, exp_ir);
      if (exp_ov) begin
        chk("y_out", y_out, q[0].y);
        chk("y_phase", y_phase, q[0].ph);
      end
      if (exp_ov && ordy) void'(q.pop_front());
      if (iv && exp_ir) begin
        longint l, hh;
        l = longint'(lo_in); hh = longint'(hi_in);
        s.ph = 0;
        s.y = g[0]*l + g[2]*lo_p + h[0]*hh + h[2]*hi_p;
        q.push_back(s);
        s.ph = 1;
        s.y = g[1]*l + g[3]*lo_p + h[1]*hh + h[3]*hi_p;
        q.push_back(s);
        lo_p = l; hi_p = hh;
      end
    end
  endtask

  localparam longint MN = -524288;

  initial begin
    set_coef(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 3, 3, 1);
    step(1, 0, 0, 0, 1);
    chk("post_reset_y", y_out, 0);
    chk("post_reset_phase", y_phase, 0);
    chk("post_reset_ready", in_ready, 1);

    // Basic pair, then back-to-back second pair
    set_coef(1, 2, 3, 4, 0, 0, 0, 0);
    step(1, 1, 100, 0, 1);
    step(1, 0, 0, 0, 1);
    chk("first_even", y_out, 100);
    set_coef(1, 2, 3, 4, 1, -1, 2, -2);
    step(1, 1, -50, 10, 1);
    chk("first_odd", y_out, 200);
    step(1, 0, 0, 0, 1);
    chk("second_even", y_out, 260);
    step(1, 0, 0, 0, 1);
    chk("second_odd", y_out, 290);

    // Extreme negative operands
    set_coef(-16, -16, -16, -16, -16, -16, -16, -16);
    step(1, 1, MN, MN, 1);
    step(1, 0, 0, 0, 1);
    step(1, 1, MN, MN, 1);
    step(1, 0, 0, 0, 1);
    chk("maxneg_even", y_out, 33554432);
    step(1, 0, 0, 0, 1);
    chk("maxneg_odd", y_out, 33554432);

    // Stall in EVEN with in_valid asserted: nothing consumed
    step(1, 1, 7, 8, 1);
    for (int i = 0; i < 5; i++) step(1, 1, 99, 99, 0);
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);

    // Reset while the odd sample is pending
    step(1, 1, 5, 6, 1);
    step(1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("rst_odd_valid", out_valid, 0);
    chk("rst_odd_ready", in_ready, 1);
    step(1, 1, 11, 12, 1);
    step(1, 0, 0, 0, 1);
    chk("rst_history_even", y_out, -368);
    step(1, 0, 0, 0, 1);

    // Sustained streaming
    rnd_coef = 1;
    for (int i = 0; i < 24; i++)
      step(1, 1, longint'($signed(W_IN'($urandom))), longint'($signed(W_IN'($urandom))), 1);

    // Fully random traffic with occasional reset
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 199) != 0), $urandom_range(0, 1),
           longint'($signed(W_IN'($urandom))), longint'($signed(W_IN'($urandom))),
           ($urandom_range(0, 3) != 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
